// File: rtl/freq_monitor.sv
// freq_monitor
// Qualifies a stream of frequency measurements against an inclusive window
// and tracks lock status with hysteresis. It also detects a stale
// measurement source and records the frequency extremes it has seen.
//
// Ports
//   clk_i        : clock; every register is clocked on its rising edge
//   rst_n_i      : asynchronous active-low reset
//   freq_i       : measured frequency in Hz
//   freq_valid_i : single-cycle strobe qualifying freq_i
//   min_freq_i   : lower bound of the acceptance window (inclusive)
//   max_freq_i   : upper bound of the acceptance window (inclusive)
//   clear_i      : clears the sticky alarm and the recorded extremes
//   state_o      : IDLE=0, ACQ=1, LOCKED=2, LOST=3
//   locked_o     : high exactly while state_o is LOCKED
//   alarm_o      : sticky loss-of-lock flag
//   stale_o      : high while the timeout counter is saturated
//   freq_min_o   : smallest sample since the last reset or clear
//   freq_max_o   : largest sample since the last reset or clear
module freq_monitor #(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 2,
  parameter int TIMEOUT    = 150_000_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] freq_i,
  input  logic        freq_valid_i,
  input  logic [31:0] min_freq_i,
  input  logic [31:0] max_freq_i,
  input  logic        clear_i,
  output logic [1:0]  state_o,
  output logic        locked_o,
  output logic        alarm_o,
  output logic        stale_o,
  output logic [31:0] freq_min_o,
  output logic [31:0] freq_max_o
);

  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT);
  localparam logic [8:0]      LOCK_N   = 9'(LOCK_CNT);
  localparam logic [8:0]      UNLOCK_N = 9'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [7:0]      good_cnt, good_next;
  logic [7:0]      bad_cnt, bad_next;
  logic [TW-1:0]   to_cnt, to_next;
  logic            alarm, alarm_next;
  logic            locked, stale;
  logic [31:0]     fmin, fmin_next, fmax, fmax_next;
  logic            in_range;
  logic            timeout_hit;
  logic            alarm_set;

  // An inverted window (min > max) can never satisfy both bounds, so it
  // naturally rejects every sample.
  assign in_range = (freq_i >= min_freq_i) && (freq_i <= max_freq_i);

  // The timeout only acts on the cycle the counter first reaches TIMEOUT,
  // so a LOCKED->LOST transition is not immediately followed by LOST->IDLE
  // while the counter sits saturated.
  assign timeout_hit = !freq_valid_i && (to_cnt == TO_MAX - TW'(1));

  // Next-state, counter, alarm and extreme-tracking logic.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    bad_next   = bad_cnt;
    alarm_set  = 1'b0;
    to_next    = to_cnt;
    fmin_next  = fmin;
    fmax_next  = fmax;

    if (freq_valid_i)
      to_next = '0;
    else if (to_cnt != TO_MAX)
      to_next = to_cnt + TW'(1);

    if (freq_valid_i) begin
      unique case (state)
        IDLE, LOST: begin
          if (in_range) begin
            // First good sample: with LOCK_CNT==1 it already completes lock.
            bad_next = '0;
            if (LOCK_N <= 9'd1) begin
              state_next = LOCKED;
              good_next  = '0;
            end else begin
              state_next = ACQ;
              good_next  = 8'd1;
            end
          end else if (state == IDLE) begin
            state_next = ACQ;
            good_next  = '0;
            bad_next   = '0;
          end
        end
        ACQ: begin
          if (in_range) begin
            if (({1'b0, good_cnt} + 9'd1) >= LOCK_N) begin
              state_next = LOCKED;
              good_next  = '0;
              bad_next   = '0;
            end else begin
              good_next = good_cnt + 8'd1;
            end
          end else begin
            good_next = '0;
          end
        end
        LOCKED: begin
          if (!in_range) begin
            if (({1'b0, bad_cnt} + 9'd1) >= UNLOCK_N) begin
              state_next = LOST;
              good_next  = '0;
              bad_next   = '0;
              alarm_set  = 1'b1;
            end else begin
              bad_next = bad_cnt + 8'd1;
            end
          end else begin
            bad_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout_hit) begin
      unique case (state)
        LOCKED: begin
          state_next = LOST;
          good_next  = '0;
          bad_next   = '0;
          alarm_set  = 1'b1;
        end
        ACQ, LOST: begin
          state_next = IDLE;
          good_next  = '0;
          bad_next   = '0;
        end
        default: ;
      endcase
    end

    // A set event overrides a simultaneous clear.
    alarm_next = alarm;
    if (alarm_set)
      alarm_next = 1'b1;
    else if (clear_i)
      alarm_next = 1'b0;

    // Clearing together with a sample restarts both extremes at that sample.
    if (clear_i && freq_valid_i) begin
      fmin_next = freq_i;
      fmax_next = freq_i;
    end else if (clear_i) begin
      fmin_next = 32'hFFFF_FFFF;
      fmax_next = 32'h0;
    end else if (freq_valid_i) begin
      fmin_next = (freq_i < fmin) ? freq_i : fmin;
      fmax_next = (freq_i > fmax) ? freq_i : fmax;
    end
  end

  // State and datapath registers; locked/stale are registered copies of
  // the next-state decode so every output comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      good_cnt <= '0;
      bad_cnt  <= '0;
      to_cnt   <= '0;
      alarm    <= 1'b0;
      locked   <= 1'b0;
      stale    <= 1'b0;
      fmin     <= 32'hFFFF_FFFF;
      fmax     <= 32'h0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
      bad_cnt  <= bad_next;
      to_cnt   <= to_next;
      alarm    <= alarm_next;
      locked   <= (state_next == LOCKED);
      stale    <= (to_next == TO_MAX);
      fmin     <= fmin_next;
      fmax     <= fmax_next;
    end
  end

  assign state_o    = state;
  assign locked_o   = locked;
  assign alarm_o    = alarm;
  assign stale_o    = stale;
  assign freq_min_o = fmin;
  assign freq_max_o = fmax;

endmodule

// File: tb/tb_freq_monitor.sv
// tb_freq_monitor
// Directed bench for freq_monitor with LOCK_CNT=3, UNLOCK_CNT=2 and a
// short TIMEOUT=10 so the stale path can be reached quickly.
module tb_freq_monitor;

  logic        clk;
  logic        rst_n;
  logic [31:0] freq;
  logic        valid;
  logic [31:0] min_freq;
  logic [31:0] max_freq;
  logic        clear;
  logic [1:0]  state;
  logic        locked;
  logic        alarm;
  logic        stale;
  logic [31:0] freq_min;
  logic [31:0] freq_max;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  freq_monitor #(
    .LOCK_CNT  (3),
    .UNLOCK_CNT(2),
    .TIMEOUT   (10)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .freq_i      (freq),
    .freq_valid_i(valid),
    .min_freq_i  (min_freq),
    .max_freq_i  (max_freq),
    .clear_i     (clear),
    .state_o     (state),
    .locked_o    (locked),
    .alarm_o     (alarm),
    .stale_o     (stale),
    .freq_min_o  (freq_min),
    .freq_max_o  (freq_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with both values.
  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one valid strobe (optionally with clear) and returns on the
  // falling edge after the sampling edge, where outputs are stable.
  task automatic apply_sample(input logic [31:0] f, input logic clr);
    @(negedge clk);
    freq  = f;
    valid = 1'b1;
    clear = clr;
    @(negedge clk);
    valid = 1'b0;
    clear = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    freq     = '0;
    valid    = 1'b0;
    clear    = 1'b0;
    min_freq = 32'd99_000_000;
    max_freq = 32'd101_000_000;

    repeat (2) @(negedge clk);
    check_value("rst_state", 32'(state), 32'd0);
    check_value("rst_locked", 32'(locked), 32'd0);
    check_value("rst_alarm", 32'(alarm), 32'd0);
    check_value("rst_stale", 32'(stale), 32'd0);
    check_value("rst_min", freq_min, 32'hFFFF_FFFF);
    check_value("rst_max", freq_max, 32'd0);
    rst_n = 1'b1;

    // Acquire lock with three in-range samples.
    apply_sample(32'd100_000_000, 1'b0);
    check_value("acq_s1", 32'(state), 32'd1);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("acq_s2", 32'(state), 32'd1);
    check_value("acq_s2_locked", 32'(locked), 32'd0);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("acq_s3", 32'(state), 32'd2);
    check_value("acq_s3_locked", 32'(locked), 32'd1);

    // Hysteresis: an isolated bad sample is forgiven, two in a row lose lock.
    apply_sample(32'd50_000_000, 1'b0);
    check_value("hyst_bad1", 32'(state), 32'd2);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("hyst_good", 32'(state), 32'd2);
    apply_sample(32'd50_000_000, 1'b0);
    check_value("hyst_bad2", 32'(state), 32'd2);
    apply_sample(32'd50_000_000, 1'b0);
    check_value("hyst_lost", 32'(state), 32'd3);
    check_value("hyst_alarm", 32'(alarm), 32'd1);
    check_value("hyst_unlocked", 32'(locked), 32'd0);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("relock_s1", 32'(state), 32'd1);
    apply_sample(32'd100_000_000, 1'b0);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("relock_s3", 32'(state), 32'd2);
    check_value("relock_alarm", 32'(alarm), 32'd1);
    check_value("ext_min", freq_min, 32'd50_000_000);
    check_value("ext_max", freq_max, 32'd100_000_000);
    clear_pulse();
    check_value("clr_alarm", 32'(alarm), 32'd0);
    check_value("clr_min", freq_min, 32'hFFFF_FFFF);
    check_value("clr_max", freq_max, 32'd0);
    check_value("clr_state", 32'(state), 32'd2);

    // Timeout from LOCKED: counter reaches 10 on the tenth edge after the strobe.
    apply_sample(32'd100_000_000, 1'b0);
    repeat (9) @(negedge clk);
    check_value("to_pre_stale", 32'(stale), 32'd0);
    check_value("to_pre_state", 32'(state), 32'd2);
    @(negedge clk);
    check_value("to_stale", 32'(stale), 32'd1);
    check_value("to_state", 32'(state), 32'd3);
    check_value("to_alarm", 32'(alarm), 32'd1);
    @(negedge clk);
    check_value("to_hold_state", 32'(state), 32'd3);
    check_value("to_hold_stale", 32'(stale), 32'd1);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("to_unstale", 32'(stale), 32'd0);
    check_value("to_reacq", 32'(state), 32'd1);

    // Extremes, and clear coinciding with a sample.
    clear_pulse();
    check_value("clr2_state", 32'(state), 32'd1);
    check_value("clr2_alarm", 32'(alarm), 32'd0);
    apply_sample(32'd5, 1'b0);
    apply_sample(32'd9, 1'b0);
    apply_sample(32'd3, 1'b0);
    check_value("ext2_min", freq_min, 32'd3);
    check_value("ext2_max", freq_max, 32'd9);
    apply_sample(32'd7, 1'b1);
    check_value("clrs_min", freq_min, 32'd7);
    check_value("clrs_max", freq_max, 32'd7);

    // Clear coinciding with loss of lock: the alarm still ends up set.
    apply_sample(32'd100_000_000, 1'b0);
    apply_sample(32'd100_000_000, 1'b0);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("lk3_state", 32'(state), 32'd2);
    check_value("lk3_max", freq_max, 32'd100_000_000);
    apply_sample(32'd50_000_000, 1'b0);
    apply_sample(32'd50_000_000, 1'b1);
    check_value("setwin_state", 32'(state), 32'd3);
    check_value("setwin_alarm", 32'(alarm), 32'd1);
    check_value("setwin_min", freq_min, 32'd50_000_000);
    check_value("setwin_max", freq_max, 32'd50_000_000);

    // Relock with the alarm still set, then reset asynchronously mid-cycle.
    apply_sample(32'd100_000_000, 1'b0);
    apply_sample(32'd100_000_000, 1'b0);
    apply_sample(32'd100_000_000, 1'b0);
    check_value("pre_rst_locked", 32'(locked), 32'd1);
    check_value("pre_rst_alarm", 32'(alarm), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_value("arst_state", 32'(state), 32'd0);
    check_value("arst_locked", 32'(locked), 32'd0);
    check_value("arst_alarm", 32'(alarm), 32'd0);
    check_value("arst_stale", 32'(stale), 32'd0);
    check_value("arst_min", freq_min, 32'hFFFF_FFFF);
    check_value("arst_max", freq_max, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Inverted window: every sample rejected, lock never reached.
    min_freq = 32'd10;
    max_freq = 32'd5;
    apply_sample(32'd7, 1'b0);
    check_value("inv_s1", 32'(state), 32'd1);
    apply_sample(32'd10, 1'b0);
    apply_sample(32'd5, 1'b0);
    check_value("inv_s3", 32'(state), 32'd1);
    check_value("inv_locked", 32'(locked), 32'd0);

    // Inclusive bounds of a normal window.
    min_freq = 32'd10;
    max_freq = 32'd20;
    apply_sample(32'd10, 1'b0);
    check_value("bnd_lo", 32'(state), 32'd1);
    apply_sample(32'd20, 1'b0);
    check_value("bnd_hi", 32'(state), 32'd1);
    apply_sample(32'd15, 1'b0);
    check_value("bnd_lock", 32'(state), 32'd2);
    apply_sample(32'd21, 1'b0);
    check_value("bnd_above", 32'(state), 32'd2);
    apply_sample(32'd9, 1'b0);
    check_value("bnd_below", 32'(state), 32'd3);
    check_value("bnd_alarm", 32'(alarm), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
